area_sorter: RTL
================

AREA_SORTER -- requirements
Module: area_sorter

Interface
REQ-001 Parameters: N, default 5, number of heptagons; AW, default 19, area width; IW, default 3, index width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 area_on  input  1  level; upstream area results are stable and complete.
REQ-005 index_in  input  N*IW  flattened indices; slot k occupies bits [k*IW +: IW].
REQ-006 area_in  input  N*AW  flattened unsigned areas; slot k occupies bits [k*AW +: AW].
REQ-007 out_ready  input  1  consumer accepts the current output beat.
REQ-008 out_valid  output  1  out_index and out_area are valid.
REQ-009 out_index  output  IW  index of the current sorted entry.
REQ-010 out_area  output  AW  area of the current sorted entry.
REQ-011 out_last  output  1  current beat is entry N-1.
REQ-012 valid_on  output  1  one-cycle acknowledge to upstream; results consumed.

Function
REQ-013 The FSM SHALL have five states: IDLE, SORT, OUT, ACK, WAIT_LOW.
REQ-014 IDLE with area_on=1: the block SHALL latch all N index/area pairs into internal arrays on that edge and enter SORT.
REQ-015 SORT SHALL run bubble sort, one compare-swap per cycle: pass p=0..N-2, position j=0..N-2, giving exactly (N-1)*(N-1)=16 cycles for N=5.
REQ-016 Swap entries j and j+1 when area[j] > area[j+1], or when the areas are equal and index[j] > index[j+1].
REQ-017 The result SHALL be ascending by area, with ties ordered by ascending index.
REQ-018 Comparisons SHALL be unsigned at full AW width, with no truncation.
REQ-019 The first out_valid SHALL assert on the 17th rising edge after the latch edge.
REQ-020 OUT: out_valid=1 presents entry k, starting at k=0; k SHALL advance only on a cycle with out_valid && out_ready.
REQ-021 While out_ready=0, out_index and out_area SHALL hold.
REQ-022 out_last SHALL equal (k==N-1) && out_valid.
REQ-023 Acceptance of the last beat SHALL move the FSM to ACK and drop out_valid on the same edge.
REQ-024 ACK: valid_on SHALL be 1 for exactly one cycle, then the FSM SHALL enter WAIT_LOW.
REQ-025 WAIT_LOW SHALL return to IDLE only when area_on=0; a held-high area_on SHALL NOT retrigger sorting.
REQ-026 area_on SHALL be ignored in SORT, OUT and ACK.
REQ-027 index_in and area_in changing after the latch edge SHALL NOT affect the outputs.
REQ-028 valid_on SHALL be 0 in every state except ACK.
REQ-029 out_valid SHALL be 0 in every state except OUT.

Reset
REQ-030 reset=1 at any edge, including mid-SORT or mid-OUT, SHALL force IDLE, out_valid=0, out_last=0, valid_on=0, out_index=0, out_area=0 and k=0.
REQ-031 Reset SHALL clear the pass/position counters; the internal arrays need not be cleared.
REQ-032 reset SHALL override area_on on the same edge.

Structure
REQ-033 A shared package SHALL hold N, AW, IW and the FSM state enumeration; area_calculation and area_sorter SHALL use that package.
REQ-034 One sub-module, area_cmp_swap, SHALL be combinational: two (index, area) pairs in, ordered pair plus a swap flag out.

Verification
REQ-035 Areas {50,40,30,20,10}, indices {1..5}, out_ready=1 -> outputs (5,10),(4,20),(3,30),(2,40),(1,50); out_last on beat 5; valid_on one cycle later.
REQ-036 Areas {7,7,3,7,3}, indices {1..5} -> order 3,5,1,2,4.
REQ-037 Areas {0,524287,1,524286,2} -> ascending order with 524287 last, proving full 19-bit compare.
REQ-038 out_ready toggling 1,0,0,1 per cycle -> no entry skipped or duplicated; outputs held while out_ready=0.
REQ-039 area_on held high through ACK for 10 cycles -> exactly one sort sequence and one valid_on pulse.
REQ-040 reset asserted at SORT cycle 8, then a new valid set -> no stale out_valid, and the new set sorts correctly.

Source files
------------

// File: rtl/area_sorter_pkg.sv
// Shared constants and FSM state encoding for the heptagon area sorting slice.
package area_sorter_pkg;

  localparam int N  = 5;   // number of heptagons per set
  localparam int AW = 19;  // unsigned area width
  localparam int IW = 3;   // heptagon index width

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SORT     = 3'd1,
    ST_OUT      = 3'd2,
    ST_ACK      = 3'd3,
    ST_WAIT_LOW = 3'd4
  } state_e;

endpackage

// File: rtl/area_sorter_if.sv
// Upstream result bus plus downstream ready/valid stream of the area sorter.
// master = the side feeding areas and consuming sorted beats, slave = the sorter.
interface area_sorter_if #(
  parameter int N  = area_sorter_pkg::N,
  parameter int AW = area_sorter_pkg::AW,
  parameter int IW = area_sorter_pkg::IW
) ();

  logic            area_on;
  logic [N*IW-1:0] index_in;
  logic [N*AW-1:0] area_in;
  logic            out_ready;
  logic            out_valid;
  logic [IW-1:0]   out_index;
  logic [AW-1:0]   out_area;
  logic            out_last;
  logic            valid_on;

  modport master (
    output area_on, index_in, area_in, out_ready,
    input  out_valid, out_index, out_area, out_last, valid_on
  );

  modport slave (
    input  area_on, index_in, area_in, out_ready,
    output out_valid, out_index, out_area, out_last, valid_on
  );

endinterface

// File: rtl/area_cmp_swap.sv
// Combinational compare-swap cell: orders two (index, area) pairs ascending by
// area, ties broken by ascending index. Compare is unsigned at full width.
module area_cmp_swap #(
  parameter int AW = area_sorter_pkg::AW,
  parameter int IW = area_sorter_pkg::IW
) (
  input  logic [IW-1:0] idx_a_i,
  input  logic [AW-1:0] area_a_i,
  input  logic [IW-1:0] idx_b_i,
  input  logic [AW-1:0] area_b_i,
  output logic [IW-1:0] lo_idx_o,
  output logic [AW-1:0] lo_area_o,
  output logic [IW-1:0] hi_idx_o,
  output logic [AW-1:0] hi_area_o,
  output logic          swap_o
);

  // Decide whether the pair is out of order and route it accordingly.
  always_comb begin
    swap_o = (area_a_i > area_b_i) || ((area_a_i == area_b_i) && (idx_a_i > idx_b_i));
    if (swap_o) begin
      lo_idx_o  = idx_b_i;
      lo_area_o = area_b_i;
      hi_idx_o  = idx_a_i;
      hi_area_o = area_a_i;
    end else begin
      lo_idx_o  = idx_a_i;
      lo_area_o = area_a_i;
      hi_idx_o  = idx_b_i;
      hi_area_o = area_b_i;
    end
  end

endmodule

// File: rtl/area_sorter.sv
// Area sorter: latches N (index, area) pairs, bubble-sorts them one compare-swap
// per cycle, streams them out over ready/valid and pulses valid_on upstream.
module area_sorter #(
  parameter int N  = area_sorter_pkg::N,
  parameter int AW = area_sorter_pkg::AW,
  parameter int IW = area_sorter_pkg::IW
) (
  input  logic         clk,
  input  logic         reset,
  area_sorter_if.slave bus
);

  import area_sorter_pkg::*;

  localparam int            CW       = $clog2(N) + 1;
  localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW-1:0] LAST_K   = CW'(N - 1);  // also the "sort finished" pass value
  localparam logic [CW-1:0] LAST_POS = CW'(N - 2);

  state_e        state_q, state_d;
  logic [CW-1:0] pass_q, pass_d, pos_q, pos_d, k_q, k_d;
  logic [CW-1:0] pos_nxt_s, k_nxt_s;
  logic          sort_busy_s, accept_s;

  logic [IW-1:0] idx_q  [N];
  logic [AW-1:0] area_q [N];

  logic          out_valid_q, out_valid_d, out_last_q, out_last_d, valid_on_q, valid_on_d;
  logic [IW-1:0] out_index_q, out_index_d;
  logic [AW-1:0] out_area_q, out_area_d;

  logic [IW-1:0] lo_idx_s, hi_idx_s;
  logic [AW-1:0] lo_area_s, hi_area_s;
  logic          swap_s;

  assign pos_nxt_s   = pos_q + ONE_C;
  assign k_nxt_s     = k_q + ONE_C;
  assign sort_busy_s = (state_q == ST_SORT) && (pass_q != LAST_K);
  assign accept_s    = out_valid_q && bus.out_ready;

  area_cmp_swap #(.AW(AW), .IW(IW)) u_cmp_swap (
    .idx_a_i  (idx_q[pos_q]),
    .area_a_i (area_q[pos_q]),
    .idx_b_i  (idx_q[pos_nxt_s]),
    .area_b_i (area_q[pos_nxt_s]),
    .lo_idx_o (lo_idx_s),
    .lo_area_o(lo_area_s),
    .hi_idx_o (hi_idx_s),
    .hi_area_o(hi_area_s),
    .swap_o   (swap_s)
  );

  // FSM state register; reset wins over everything including area_on.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; area_on only matters in IDLE and WAIT_LOW.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     state_d = bus.area_on ? ST_SORT : ST_IDLE;
      ST_SORT:     state_d = (pass_q == LAST_K) ? ST_OUT : ST_SORT;
      ST_OUT:      state_d = (accept_s && (k_q == LAST_K)) ? ST_ACK : ST_OUT;
      ST_ACK:      state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: state_d = bus.area_on ? ST_WAIT_LOW : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Counter and output next-values; the output beat is preloaded from entry 0
  // on the edge that leaves SORT so out_valid is registered with its data.
  always_comb begin
    pass_d      = pass_q;
    pos_d       = pos_q;
    k_d         = k_q;
    out_index_d = out_index_q;
    out_area_d  = out_area_q;
    out_last_d  = out_last_q;
    out_valid_d = (state_d == ST_OUT);
    valid_on_d  = (state_d == ST_ACK);
    case (state_q)
      ST_IDLE: begin
        pass_d     = ZERO_C;
        pos_d      = ZERO_C;
        k_d        = ZERO_C;
        out_last_d = 1'b0;
      end
      ST_SORT: begin
        if (sort_busy_s) begin
          if (pos_q == LAST_POS) begin
            pos_d  = ZERO_C;
            pass_d = pass_q + ONE_C;
          end else begin
            pos_d  = pos_nxt_s;
          end
        end else begin
          k_d         = ZERO_C;
          out_index_d = idx_q[0];
          out_area_d  = area_q[0];
          out_last_d  = (LAST_K == ZERO_C);
        end
      end
      ST_OUT: begin
        if (accept_s) begin
          if (k_q == LAST_K) begin
            k_d        = ZERO_C;
            out_last_d = 1'b0;
          end else begin
            k_d         = k_nxt_s;
            out_index_d = idx_q[k_nxt_s];
            out_area_d  = area_q[k_nxt_s];
            out_last_d  = (k_nxt_s == LAST_K);
          end
        end else begin
          k_d = k_q;
        end
      end
      ST_ACK, ST_WAIT_LOW: begin
        out_last_d = 1'b0;
      end
      default: begin
        out_last_d = 1'b0;
      end
    endcase
  end

  // Counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pass_q      <= ZERO_C;
      pos_q       <= ZERO_C;
      k_q         <= ZERO_C;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      valid_on_q  <= 1'b0;
      out_index_q <= {IW{1'b0}};
      out_area_q  <= {AW{1'b0}};
    end else begin
      pass_q      <= pass_d;
      pos_q       <= pos_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      valid_on_q  <= valid_on_d;
      out_index_q <= out_index_d;
      out_area_q  <= out_area_d;
    end
  end

  // Working arrays: capture the set on the start edge, then one compare-swap per sort cycle.
  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && bus.area_on && !reset) begin
      for (int s = 0; s < N; s++) begin
        idx_q[s]  <= bus.index_in[s*IW +: IW];
        area_q[s] <= bus.area_in[s*AW +: AW];
      end
    end else if (sort_busy_s && swap_s) begin
      idx_q[pos_q]      <= lo_idx_s;
      area_q[pos_q]     <= lo_area_s;
      idx_q[pos_nxt_s]  <= hi_idx_s;
      area_q[pos_nxt_s] <= hi_area_s;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.valid_on  = valid_on_q;
  assign bus.out_index = out_index_q;
  assign bus.out_area  = out_area_q;

endmodule
